// File: rtl/skew_sync_epoch_ctrl_if.sv
// Bus bundle for skew_sync_epoch_ctrl: epoch control, input bit pairs and
// synchronized output pairs with status.
interface skew_sync_epoch_ctrl_if #(
  parameter int DEP = 2,
  parameter int LW  = 8
);
  logic           start;
  logic [LW-1:0]  len;
  logic           in_valid;
  logic           in0;
  logic           in1;
  logic           out0;
  logic           out1;
  logic           out_valid;
  logic           busy;
  logic           done;
  logic [DEP-1:0] resid;

  modport master (
    output start, len, in_valid, in0, in1,
    input  out0, out1, out_valid, busy, done, resid
  );

  modport slave (
    input  start, len, in_valid, in0, in1,
    output out0, out1, out_valid, busy, done, resid
  );
endinterface

// File: rtl/skew_sync_epoch_ctrl.sv
// Epoch-based unary bitstream skew synchronizer with saturating skew counter.
// Optional residual flush phase enabled by macro SKEW_SYNC_FLUSH_EN.
module skew_sync_epoch_ctrl #(
  parameter int DEP = 2,
  parameter int LW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  skew_sync_epoch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
`ifdef SKEW_SYNC_FLUSH_EN
    FLUSH = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  localparam logic [DEP-1:0] CNT_MAX = '1;

  state_t         state_q, state_d;
  logic [DEP-1:0] cnt_q, cnt_d;
  logic [LW-1:0]  ecnt_q, ecnt_d;
  logic [LW-1:0]  len_q, len_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ecnt_d        = ecnt_q;
    len_d         = len_q;
    bus.out0      = 1'b0;
    bus.out1      = 1'b0;
    bus.out_valid = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_d = RUN;
            len_d   = bus.len;
            ecnt_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        bus.out_valid = bus.in_valid;
        if (bus.in_valid) begin
          bus.out1 = bus.in1;
          case ({bus.in0, bus.in1})
            2'b10: begin
              // a leading 1 on in0 is deferred into the counter unless full
              if (cnt_q == CNT_MAX) bus.out0 = 1'b1;
              else                  cnt_d    = cnt_q + 1'b1;
            end
            2'b01: begin
              if (cnt_q != '0) begin
                bus.out0 = 1'b1;
                cnt_d    = cnt_q - 1'b1;
              end
            end
            default: bus.out0 = bus.in0;
          endcase
          ecnt_d = ecnt_q + LW'(1);
          if (ecnt_q == len_q - LW'(1)) begin
`ifdef SKEW_SYNC_FLUSH_EN
            state_d = FLUSH;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef SKEW_SYNC_FLUSH_EN
      FLUSH: begin
        if (cnt_q != '0) begin
          bus.out_valid = 1'b1;
          bus.out0      = 1'b1;
          cnt_d         = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
`ifndef SKEW_SYNC_FLUSH_EN
        // residual skew is dropped when there is no flush phase
        cnt_d    = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef SKEW_SYNC_FLUSH_EN
    bus.busy = (state_q == RUN) || (state_q == FLUSH);
`else
    bus.busy = (state_q == RUN);
`endif
  end

  assign bus.resid = cnt_q;

endmodule

// File: tb/tb_skew_sync_epoch_ctrl.sv
// Directed scoreboard bench for skew_sync_epoch_ctrl; output pairs are
// predicted as stimulus is driven and matched when out_valid appears.
module tb_skew_sync_epoch_ctrl;
  localparam int DEP  = 2;
  localparam int LW   = 8;
  localparam int MAXC = (1 << DEP) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  skew_sync_epoch_ctrl_if #(.DEP(DEP), .LW(LW)) bus ();
  skew_sync_epoch_ctrl #(.DEP(DEP), .LW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];
  int model_cnt = 0;
  int acc = 0;
  int elen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("out_pair", {30'd0, bus.out0, bus.out1}, {30'd0, e});
      end
    end
  end

  task automatic start_epoch(input int l);
    bus.start = 1'b1;
    bus.len   = LW'(l);
    @(posedge clk); #1;
    bus.start = 1'b0;
    elen = l; acc = 0; model_cnt = 0;
    chk("busy_after_start", {31'd0, bus.busy}, (l != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic pair(input logic v, input logic a, input logic b);
    logic e0;
    bus.in_valid = v; bus.in0 = a; bus.in1 = b;
    #1;
    if (!v) begin
      chk("idle_cycle_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("idle_cycle_outs", {30'd0, bus.out0, bus.out1}, 32'd0);
      chk("idle_cycle_busy", {31'd0, bus.busy}, 32'd1);
      chk("idle_cycle_done", {31'd0, bus.done}, 32'd0);
    end else begin
      if (a == b) e0 = a;
      else if (a) begin
        if (model_cnt == MAXC) e0 = 1'b1;
        else begin e0 = 1'b0; model_cnt++; end
      end else begin
        if (model_cnt == 0) e0 = 1'b0;
        else begin e0 = 1'b1; model_cnt--; end
      end
      exp_q.push_back({e0, b});
      acc++;
`ifdef SKEW_SYNC_FLUSH_EN
      if (acc == elen) for (int i = 0; i < model_cnt; i++) exp_q.push_back(2'b10);
`endif
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("resid", {30'd0, bus.resid}, model_cnt);
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (bus.done !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
    chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("resid_after_done", {30'd0, bus.resid}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0;
    bus.in_valid = 1'b0; bus.in0 = 1'b0; bus.in1 = 1'b0;
    #3;
    chk("rst_outs", {28'd0, bus.out0, bus.out1, bus.out_valid, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_resid", {30'd0, bus.resid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // len=4: (1,0),(1,0),(0,1),(1,1)
    start_epoch(4);
    pair(1, 1, 0); pair(1, 1, 0); pair(1, 0, 1); pair(1, 1, 1);
    wait_done(20);

    // len=5, counter saturates at 3
    start_epoch(5);
    repeat (5) pair(1, 1, 0);
    wait_done(20);

    // len=0 goes straight to DONE
    start_epoch(0);
    wait_done(3);

    // len=3 with in_valid toggling
    start_epoch(3);
    pair(1, 1, 0); pair(0, 1, 1); pair(1, 1, 0); pair(0, 1, 0); pair(1, 0, 0);
    wait_done(20);

    // reset mid-RUN with cnt=2
    start_epoch(7);
    pair(1, 1, 0); pair(1, 1, 0);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_resid", {30'd0, bus.resid}, 32'd0);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, bus.done}, 32'd0);
    end
    @(posedge clk); #1;

    // start during RUN is ignored; len=7 still governs the exit
    start_epoch(7);
    pair(1, 1, 0); pair(1, 1, 0);
    bus.start = 1'b1; bus.len = LW'(2);
    pair(0, 1, 1);
    bus.start = 1'b0;
    pair(1, 0, 1); pair(1, 1, 1); pair(1, 1, 0); pair(0, 0, 0); pair(1, 0, 0); pair(1, 1, 0);
    wait_done(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/skew_sync_epoch_ctrl.md
SKEW_SYNC_EPOCH_CTRL -- requirements
Module: skew_sync_epoch_ctrl

Interface
REQ-001 SHALL have parameter DEP, default 2: skew counter width in bits; max stored skew is 2^DEP-1.
REQ-002 SHALL have parameter LW, default 8: epoch length field width; max epoch is 2^LW-1 accepted bit pairs.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin an epoch.
REQ-006 SHALL have port len, input, LW: epoch length, sampled only when start is accepted.
REQ-007 SHALL have port in_valid, input, 1: in0/in1 carry a valid bit pair this cycle.
REQ-008 SHALL have ports in0 and in1, input, 1 each: unary bitstream bits.
REQ-009 SHALL have ports out0 and out1, output, 1 each: synchronized bitstream bits.
REQ-010 SHALL have port out_valid, output, 1: out0/out1 are valid this cycle.
REQ-011 SHALL have port busy, output, 1: high in RUN and FLUSH.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at epoch completion.
REQ-013 SHALL have port resid, output, DEP: current skew counter value.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, FLUSH and DONE, with registered state.
REQ-015 SHALL, in IDLE, move to RUN on start=1 when len>0, latch len, clear the epoch counter ecnt (LW bits) and clear the skew counter cnt.
REQ-016 SHALL, in IDLE, move directly to DONE on start=1 when len=0.
REQ-017 SHALL ignore start in RUN, FLUSH and DONE, with no effect on any state.
REQ-018 SHALL, in RUN, treat a cycle with in_valid=1 as an accepted pair and increment ecnt; on the accepted pair with ecnt==len-1, move to FLUSH.
REQ-019 SHALL, for an accepted RUN pair, process the bits combinationally in the same cycle as follows:
- out1=in1.
- If in0==in1: out0=in0 and cnt holds.
- If in0=1 and in1=0: when cnt is full (all ones), out0=1 and cnt holds; otherwise out0=0 and cnt increments.
- If in0=0 and in1=1: when cnt=0, out0=0 and cnt holds; otherwise out0=1 and cnt decrements.
REQ-020 SHALL drive out_valid=in_valid in RUN; when in_valid=0, it SHALL drive out0=out1=0 and leave cnt and ecnt unchanged.
REQ-021 SHALL, in FLUSH, drive out_valid=1, out0=1 and out1=0 each cycle while cnt>0 and decrement cnt; it SHALL move to DONE in the cycle cnt==0 is observed, and that cycle has out_valid=0.
REQ-022 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-023 SHALL drive out_valid=0 and out0=out1=0 in IDLE and DONE.
REQ-024 SHALL make resid equal to cnt at all times.
REQ-025 SHALL never wrap cnt; it saturates at 0 and at 2^DEP-1.
REQ-026 SHALL never wrap ecnt past len, since the RUN-to-FLUSH exit precludes it.

Reset
REQ-027 SHALL, on rst=1, immediately force the following regardless of clock: state=IDLE, cnt=0, ecnt=0, latched len=0.
REQ-028 SHALL hold these reset output values: out0=0, out1=0, out_valid=0, busy=0, done=0, resid=0.
REQ-029 SHALL discard any in-progress epoch on mid-operation reset, with no done pulse.

Configuration
REQ-030 SHALL use macro SKEW_SYNC_FLUSH_EN: when defined, FLUSH behaves per REQ-021.
REQ-031 SHALL, when SKEW_SYNC_FLUSH_EN is undefined, omit the FLUSH state: RUN moves directly to DONE, residual cnt is discarded and cleared in DONE, and resid reads 0 after DONE.

Verification
REQ-032 SHALL cover: DEP=2, len=4, pairs (1,0),(1,0),(0,1),(1,1) -> out0=0,0,1,1, out1=0,0,1,1, cnt 1,2,1,1; FLUSH emits one (1,0) pair, then done.
REQ-033 SHALL cover: DEP=2, len=5, five (1,0) pairs -> out0=0,0,0,1,1, cnt saturates at 3; FLUSH emits 3 cycles, then done.
REQ-034 SHALL cover: len=0 start -> DONE next cycle, done pulse one cycle, out_valid never asserted.
REQ-035 SHALL cover: len=3 with in_valid toggling 1,0,1,0,1 -> FSM leaves RUN only after the 3rd accepted pair, and out_valid mirrors in_valid.
REQ-036 SHALL cover: rst asserted mid-RUN with cnt=2 -> immediately busy=0, resid=0, and no done pulse follows.
REQ-037 SHALL cover: start pulsed during RUN with len=7 -> ignored, and the original len still governs the exit.
